// File: rtl/oc8051_ram_pkg.sv
// Shared encodings for the bit-addressable RAM front end.
// ST_CLR exists only when OC8051_RAM_CLR_EN is defined.
package oc8051_ram_pkg;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_BSET = 2'b10,
    OP_BCPL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_WB   = 3'd4,
`ifdef OC8051_RAM_CLR_EN
    ST_CLR  = 3'd1,
`endif
    ST_WR   = 3'd5
  } state_e;

  localparam logic [7:0] BIT_BASE = 8'h20;

  // Operation captured at the accept edge; addr is already the byte address.
  typedef struct packed {
    op_e        op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] bit_idx;
    logic       bit_val;
  } req_t;

endpackage

// File: rtl/oc8051_bit_map.sv
// Combinational bit-address decode: low half maps into the 0x20..0x2F bit area,
// high half addresses the SFR byte whose low three address bits are zero.
module oc8051_bit_map
  import oc8051_ram_pkg::*;
(
  input  logic [7:0] bit_addr,
  output logic [7:0] byte_addr,
  output logic [2:0] bit_idx
);

  always_comb begin
    if (!bit_addr[7]) begin
      byte_addr = BIT_BASE + {4'h0, bit_addr[6:3]};
    end else begin
      byte_addr = {bit_addr[7:3], 3'b000};
    end
    bit_idx = bit_addr[2:0];
  end

endmodule

// File: rtl/oc8051_ram_bitop.sv
// Byte read/write and read-modify-write bit ops on a sync-read RAM; latency RD 3, WR 2, bit op 4.
// Requests are sampled only when idle; optional power-up clear via OC8051_RAM_CLR_EN.
module oc8051_ram_bitop
  import oc8051_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [7:0] addr,
  input  logic [7:0] bit_addr,
  input  logic [7:0] wdata,
  input  logic       bit_val,
  output logic       busy,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       bit_out,
  output logic [7:0] ram_rd_addr,
  input  logic [7:0] ram_rd_data,
  output logic [7:0] ram_wr_addr,
  output logic [7:0] ram_wr_data,
  output logic       ram_wr
);

  state_e     state_q, state_d;
  req_t       cur_q, cur_d;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic       bit_out_q, bit_out_d;
  logic [7:0] ram_rd_addr_q, ram_rd_addr_d;
  logic       ram_wr_q, ram_wr_d;
  logic [7:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [7:0] ram_wr_data_q, ram_wr_data_d;
`ifdef OC8051_RAM_CLR_EN
  logic [8:0] clr_cnt_q, clr_cnt_d;
`endif

  logic [7:0] map_byte;
  logic [2:0] map_idx;
  logic       old_bit;
  logic [7:0] new_byte;

  oc8051_bit_map u_bit_map (
    .bit_addr  (bit_addr),
    .byte_addr (map_byte),
    .bit_idx   (map_idx)
  );

  always_comb begin
    old_bit  = ram_rd_data[cur_q.bit_idx];
    new_byte = ram_rd_data;
    if (cur_q.op == OP_BSET) begin
      new_byte[cur_q.bit_idx] = cur_q.bit_val;
    end else begin
      new_byte[cur_q.bit_idx] = ~old_bit;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    ack_d         = 1'b0;
    rdata_d       = rdata_q;
    bit_out_d     = bit_out_q;
    ram_rd_addr_d = ram_rd_addr_q;
    ram_wr_d      = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
`ifdef OC8051_RAM_CLR_EN
    clr_cnt_d     = clr_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cur_d.op      = op_e'(op);
          cur_d.wdata   = wdata;
          cur_d.bit_val = bit_val;
          cur_d.bit_idx = map_idx;
          if (op_e'(op) == OP_RD || op_e'(op) == OP_WR) begin
            cur_d.addr = addr;
          end else begin
            cur_d.addr = map_byte;
          end
          if (op_e'(op) == OP_WR) begin
            ram_wr_d      = 1'b1;
            ram_wr_addr_d = addr;
            ram_wr_data_d = wdata;
            state_d       = ST_WR;
          end else begin
            ram_rd_addr_d = (op_e'(op) == OP_RD) ? addr : map_byte;
            state_d       = ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      // Read data is valid here; RD finishes, bit ops compute the modified byte.
      ST_CAP: begin
        if (cur_q.op == OP_RD) begin
          rdata_d   = ram_rd_data;
          bit_out_d = 1'b0;
          ack_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          rdata_d       = new_byte;
          bit_out_d     = old_bit;
          ram_wr_d      = 1'b1;
          ram_wr_addr_d = cur_q.addr;
          ram_wr_data_d = new_byte;
          state_d       = ST_WB;
        end
      end
      ST_WB: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_WR: begin
        rdata_d   = cur_q.wdata;
        bit_out_d = 1'b0;
        ack_d     = 1'b1;
        state_d   = ST_IDLE;
      end
`ifdef OC8051_RAM_CLR_EN
      // Counter bit 8 marks that all 256 clear writes have been issued.
      ST_CLR: begin
        if (clr_cnt_q[8]) begin
          state_d = ST_IDLE;
        end else begin
          ram_wr_d      = 1'b1;
          ram_wr_addr_d = clr_cnt_q[7:0];
          ram_wr_data_d = 8'h00;
          clr_cnt_d     = clr_cnt_q + 9'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef OC8051_RAM_CLR_EN
      state_q   <= ST_CLR;
      clr_cnt_q <= 9'd0;
`else
      state_q   <= ST_IDLE;
`endif
      cur_q         <= '0;
      ack_q         <= 1'b0;
      rdata_q       <= 8'h00;
      bit_out_q     <= 1'b0;
      ram_rd_addr_q <= 8'h00;
      ram_wr_q      <= 1'b0;
      ram_wr_addr_q <= 8'h00;
      ram_wr_data_q <= 8'h00;
    end else begin
`ifdef OC8051_RAM_CLR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
      state_q       <= state_d;
      cur_q         <= cur_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      bit_out_q     <= bit_out_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      ram_wr_q      <= ram_wr_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign bit_out     = bit_out_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign ram_wr      = ram_wr_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;

endmodule

// File: tb/tb_oc8051_ram_bitop.sv
// Directed bench for oc8051_ram_bitop with a sync-read RAM model and a result scoreboard.
module tb_oc8051_ram_bitop;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] op;
  logic [7:0] addr, bit_addr, wdata;
  logic       bit_val;
  logic       busy, ack, bit_out, ram_wr;
  logic [7:0] rdata, ram_rd_addr, ram_rd_data, ram_wr_addr, ram_wr_data;

  oc8051_ram_bitop dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .op          (op),
    .addr        (addr),
    .bit_addr    (bit_addr),
    .wdata       (wdata),
    .bit_val     (bit_val),
    .busy        (busy),
    .ack         (ack),
    .rdata       (rdata),
    .bit_out     (bit_out),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr      (ram_wr)
  );

  always #5 clk = ~clk;

  // RAM model; bench-side preloads go through the same process.
  logic [7:0] mem [0:255];
  logic       pl_en = 1'b0, pl_fill = 1'b0;
  logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;

  always @(posedge clk) begin
    ram_rd_data <= mem[ram_rd_addr];
    if (ram_wr === 1'b1) mem[ram_wr_addr] <= ram_wr_data;
    if (pl_fill) for (int i = 0; i < 256; i++) mem[i] <= pl_data;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  int         wr_cnt = 0;
  logic [7:0] last_wa = 8'h00, last_wd = 8'h00;
  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      wr_cnt++;
      last_wa = ram_wr_addr;
      last_wd = ram_wr_data;
    end
  end

  typedef struct {
    logic [7:0] rdata;
    logic       bit_out;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic fill(input logic [7:0] d);
    pl_data = d; pl_fill = 1'b1;
    @(posedge clk); #1;
    pl_fill = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] ba, input logic [7:0] wd, input logic bv,
                       input logic [7:0] er, input logic eb, input int el);
    exp_t e;
    int   cyc;
    bit   got;
    e.rdata = er; e.bit_out = eb; e.lat = el;
    sb.push_back(e);
    req = 1'b1; op = o; addr = a; bit_addr = ba; wdata = wd; bit_val = bv;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      if (ack === 1'b1) got = 1'b1;
    end
    req = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      check({tag, ".ack_timeout"}, {31'd0, ack}, 32'd1);
    end else begin
      check({tag, ".lat"}, cyc, e.lat);
      check({tag, ".rdata"}, {24'd0, rdata}, {24'd0, e.rdata});
      check({tag, ".bit_out"}, {31'd0, bit_out}, {31'd0, e.bit_out});
      check({tag, ".idle_in_ack"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int w0;
    int nack;
    rst = 1'b0; req = 1'b0; op = 2'b00; addr = 8'h00; bit_addr = 8'h00;
    wdata = 8'h00; bit_val = 1'b0;
    @(posedge clk); #1;
`ifdef OC8051_RAM_CLR_EN
    fill(8'hFF);
`else
    fill(8'h00);
`endif
    check("rst.ack", {31'd0, ack}, 32'd0);
    check("rst.rdata", {24'd0, rdata}, 32'd0);
    check("rst.bit_out", {31'd0, bit_out}, 32'd0);
    check("rst.ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst.addrs", {8'd0, ram_rd_addr, ram_wr_addr, ram_wr_data}, 32'd0);
`ifdef OC8051_RAM_CLR_EN
    check("rst.busy", {31'd0, busy}, 32'd1);
    begin
      int good_wr, busy_hi;
      good_wr = 0; busy_hi = 0; nack = 0;
      rst = 1'b1;
      req = 1'b1; op = 2'b00; addr = 8'h35;
      for (int k = 1; k <= 257; k++) begin
        @(posedge clk); #1;
        if (ack === 1'b1) nack++;
        if (k <= 256) begin
          if (ram_wr === 1'b1 && ram_wr_addr == 8'(k - 1) && ram_wr_data == 8'h00) good_wr++;
          if (busy === 1'b1) busy_hi++;
        end
        if (k == 256) req = 1'b0;
        if (k == 257) check("clr.busy_low_257", {31'd0, busy}, 32'd0);
      end
      check("clr.writes", good_wr, 256);
      check("clr.busy_high", busy_hi, 256);
      check("clr.req_ignored", nack, 0);
      check("clr.mem35", {24'd0, mem[8'h35]}, 32'd0);
      check("clr.memff", {24'd0, mem[8'hFF]}, 32'd0);
    end
`else
    check("rst.busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
`endif
    preload(8'h35, 8'hA5);
    preload(8'hE0, 8'hFF);

    w0 = wr_cnt;
    do_op("rd35", 2'b00, 8'h35, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 3);
    check("rd35.no_write", wr_cnt - w0, 0);

    w0 = wr_cnt;
    do_op("wr10", 2'b01, 8'h10, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0, 2);
    do_op("rd10", 2'b00, 8'h10, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0, 3);
    check("wr10.pulses", wr_cnt - w0, 1);
    check("wr10.wr_addr_data", {16'd0, last_wa, last_wd}, 32'h103C);
    check("rd10.rd_addr_hold", {24'd0, ram_rd_addr}, 32'h10);

    w0 = wr_cnt;
    do_op("bset0b", 2'b10, 8'h00, 8'h0B, 8'h00, 1'b1, 8'h08, 1'b0, 4);
    check("bset0b.pulses", wr_cnt - w0, 1);
    check("bset0b.wr", {16'd0, last_wa, last_wd}, 32'h2108);

    do_op("bcple7", 2'b11, 8'h00, 8'hE7, 8'h00, 1'b0, 8'h7F, 1'b1, 4);
    check("bcple7.wr", {16'd0, last_wa, last_wd}, 32'hE07F);
    do_op("rde0", 2'b00, 8'hE0, 8'h00, 8'h00, 1'b0, 8'h7F, 1'b0, 3);
    do_op("bclr0b", 2'b10, 8'h00, 8'h0B, 8'h00, 1'b0, 8'h00, 1'b1, 4);
    do_op("bset7f", 2'b10, 8'h00, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 4);
    check("bset7f.wr", {16'd0, last_wa, last_wd}, 32'h2F80);
    do_op("bcpl81", 2'b11, 8'h00, 8'h81, 8'h00, 1'b0, 8'h02, 1'b0, 4);
    check("bcpl81.mem80", {24'd0, mem[8'h80]}, 32'h02);

    // Abort a BSET with reset during its CAP cycle.
    req = 1'b1; op = 2'b10; bit_addr = 8'h0B; bit_val = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    w0 = wr_cnt;
    @(posedge clk); #1;
    check("abort.ack", {31'd0, ack}, 32'd0);
    check("abort.ram_wr", {31'd0, ram_wr}, 32'd0);
    check("abort.rdata_bit", {23'd0, rdata, bit_out}, 32'd0);
    check("abort.addrs", {8'd0, ram_rd_addr, ram_wr_addr, ram_wr_data}, 32'd0);
    rst = 1'b1;
    nack = 0;
`ifdef OC8051_RAM_CLR_EN
    for (int k = 0; k < 300 && busy !== 1'b0; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) nack++;
    end
    check("abort.clr_done", {31'd0, busy}, 32'd0);
`else
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) nack++;
    end
    check("abort.no_write", wr_cnt - w0, 0);
    check("abort.mem21", {24'd0, mem[8'h21]}, 32'h00);
`endif
    check("abort.no_ack", nack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
